sat_round_pipe: RTL
===================

// Module: sat_round_pipe
// PURPOSE
//  Pipelined signed requantiser: drops NB_FRAC_DROP LSBs with a selectable rounding mode, then
//  saturates or wraps the result to NBW_OUT bits. Valid/ready streaming, 2-cycle latency.
//  Overflow events are reported per beat, in a sticky flag and in a saturating counter.
//  Sits between datapath arithmetic (MAC/filter outputs) and narrower downstream consumers.
// PARAMETERS
//  NBW_IN       16  input width, signed two's complement
//  NBW_OUT      8   output width, signed; legal range NBW_OUT <= NBW_IN-NB_FRAC_DROP
//  NB_FRAC_DROP 4   LSBs removed by rounding; 0 = no rounding stage arithmetic (pass-through)
//  SYM_SAT      0   1: negative clamp is -(2^(NBW_OUT-1)-1); 0: -(2^(NBW_OUT-1))
//  NB_CNT       16  overflow counter width
// PORTS
//  i_clk        in   1            clock, all logic on rising edge
//  i_rst_n      in   1            reset, synchronous, active-low
//  i_valid      in   1            input beat valid
//  o_ready      out  1            block can accept input this cycle
//  i_data       in   NBW_IN       signed input sample
//  i_mode       in   2            0 trunc(floor), 1 round-half-up, 2 round-half-even, 3 = trunc
//  i_sat_en     in   1            1 saturate, 0 wrap (keep low NBW_OUT bits)
//  o_valid      out  1            output beat valid
//  i_ready      in   1            downstream accepts output
//  o_data       out  NBW_OUT      signed result
//  o_sat_hit    out  1            qualified by o_valid: this beat overflowed the output range
//  i_ovf_clr    in   1            clears o_ovf_flag and o_ovf_cnt
//  o_ovf_flag   out  1            sticky: any overflow since reset/clear
//  o_ovf_cnt    out  NB_CNT       overflow beats since reset/clear, saturates at all-ones
// BEHAVIOUR
//  - Reset (i_rst_n=0 at edge): both stage valids, o_valid, o_data, o_sat_hit, o_ovf_flag and
//    o_ovf_cnt go to 0. Pipeline contents are discarded; o_ready=1 in the first cycle after reset.
//  - Handshake: transfer on valid&ready at each side. o_ready = !s1_vld | s1_adv;
//    s1_adv = !s2_vld | i_ready. No combinational path i_valid->o_valid. Back-to-back with
//    i_ready=1 gives 1 beat/cycle, latency 2. While o_valid=1 and i_ready=0, o_data,
//    o_sat_hit and o_valid hold stable.
//  - i_mode and i_sat_en are sampled with the beat in S1 and carried with it (per-beat mode).
//  - S1 rounding, width W1 = NBW_IN-NB_FRAC_DROP+1 (extra MSB absorbs rounding carry):
//    trunc: x>>>D; half-up: (x + 2^(D-1))>>>D; half-even: half-up, except when the
//    dropped bits equal exactly 100..0 and the kept LSB is 0 -> trunc. D=0: all modes = x.
//  - S2 saturation: MAX=2^(NBW_OUT-1)-1, MIN=-2^(NBW_OUT-1) (+1 if SYM_SAT). hit = r>MAX | r<MIN.
//    sat_en=1: clamp to MAX/MIN; sat_en=0: o_data = r[NBW_OUT-1:0]. o_sat_hit = hit in
//    both cases. With SYM_SAT=1, r=-2^(NBW_OUT-1) is a hit.
//  - Counters update when an output beat with hit=1 transfers (o_valid&i_ready). flag<=1;
//    cnt<=cnt+1 unless all-ones (holds).
//  - i_ovf_clr same cycle as a counted transfer: clear wins first, then the event counts
//    (cnt=1, flag=1). i_ovf_clr does not affect the datapath.
//  - Elaboration: $error if NBW_OUT > NBW_IN-NB_FRAC_DROP or NBW_OUT < 2.
// STRUCTURE
//  - Package sat_pkg: typedef enum logic [1:0] rnd_mode_e {RND_TRUNC, RND_HALF_UP,
//    RND_HALF_EVEN, RND_RSVD}; shared status struct {sat_hit}.
//  - Sub-module rnd_core (combinational, parametrised NBW_IN/NB_FRAC_DROP): rounding for S1.
//    Saturation, pipeline registers and counters live in the top.
// TESTING  (NBW_IN=16, NB_FRAC_DROP=4, NBW_OUT=8, SYM_SAT=0 unless stated)
//  1 0x0018(+1.5): trunc->1, half-up->2, half-even->2; 0x0028(+2.5): half-even->2, half-up->3.
//  2 0xFFE8(-1.5): trunc->-2, half-up->-1, half-even->-2; no o_sat_hit.
//  3 0x7FF8 half-up, sat_en=1 -> 127, hit=1; sat_en=0 -> wrap 0x00, hit=1;
//    0x8000 -> -128 hit=1; SYM_SAT=1 -> -127, hit=1.
//  4 Stream 20 beats, i_ready toggles 1/0 randomly: outputs match model in order,
//    no loss/dup, o_data stable during stall, latency 2 when unstalled.
//  5 NB_CNT=2: 5 overflow beats -> cnt 1,2,3,3,3; i_ovf_clr with overflow transfer -> cnt=1,
//    flag=1; clr alone -> 0,0.
//  6 i_rst_n=0 mid-stream with 2 beats in flight -> o_valid=0, cnt=0 next cycle;
//    no stale beat emitted after release.

Source files
------------

// File: rtl/sat_pkg.sv
// Shared types for the saturating requantiser: rounding-mode encoding and per-beat status.
package sat_pkg;

   typedef enum logic [1:0] {
      RND_TRUNC,
      RND_HALF_UP,
      RND_HALF_EVEN,
      RND_RSVD
   } rnd_mode_e;

   typedef struct packed {
      logic sat_hit;
   } sat_status_t;

endpackage

// File: rtl/rnd_core.sv
// Combinational rounding: drops NB_FRAC_DROP LSBs of a signed sample into a result one bit
// wider than the kept field so the rounding carry can never overflow.
module rnd_core
   import sat_pkg::*;
#(
   parameter int NBW_IN       = 16,
   parameter int NB_FRAC_DROP = 4
) (
   input  logic [NBW_IN-1:0]            x,
   input  rnd_mode_e                    mode,
   output logic [NBW_IN-NB_FRAC_DROP:0] r
);

   if (NB_FRAC_DROP == 0) begin : g_pass
      logic unused_mode;
      assign unused_mode = ^mode;
      assign r = {x[NBW_IN-1], x};
   end else begin : g_rnd
      localparam int D = NB_FRAC_DROP;
      localparam logic [NBW_IN:0] HALF = {{NBW_IN{1'b0}}, 1'b1} << (D - 1);

      logic [NBW_IN:0] xe;
      logic [NBW_IN:0] xr;
      logic            tie_even;

      assign xe = {x[NBW_IN-1], x};
      assign xr = xe + HALF;
      // Exact half with an even kept LSB rounds down instead of up.
      assign tie_even = (x[D-1:0] == HALF[D-1:0]) && !x[D];

      always_comb begin
         r = xe[NBW_IN:D];
         case (mode)
            RND_HALF_UP:   r = xr[NBW_IN:D];
            RND_HALF_EVEN: r = tie_even ? xe[NBW_IN:D] : xr[NBW_IN:D];
            default:       r = xe[NBW_IN:D];
         endcase
      end
   end

endmodule

// File: rtl/sat_round_pipe.sv
// Two-stage valid/ready requantiser: S1 rounds, S2 saturates or wraps; overflow beats feed a
// sticky flag and a saturating counter.
module sat_round_pipe
   import sat_pkg::*;
#(
   parameter int NBW_IN       = 16,
   parameter int NBW_OUT      = 8,
   parameter int NB_FRAC_DROP = 4,
   parameter int SYM_SAT      = 0,
   parameter int NB_CNT       = 16
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [NBW_IN-1:0]  i_data,
   input  logic [1:0]         i_mode,
   input  logic               i_sat_en,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [NBW_OUT-1:0] o_data,
   output logic               o_sat_hit,
   input  logic               i_ovf_clr,
   output logic               o_ovf_flag,
   output logic [NB_CNT-1:0]  o_ovf_cnt
);

   localparam int W1 = NBW_IN - NB_FRAC_DROP + 1;

   if ((NBW_OUT > NBW_IN - NB_FRAC_DROP) || (NBW_OUT < 2)) begin : g_bad_cfg
      $error("sat_round_pipe: illegal NBW_OUT for given NBW_IN/NB_FRAC_DROP");
   end

   logic                 s1_vld;
   logic                 s1_adv;
   logic                 s1_sat_en;
   logic [W1-1:0]        s1_r;
   logic [W1-1:0]        rnd_r;
   logic                 s2_vld;
   sat_status_t          st_d;
   sat_status_t          st_q;
   logic [NBW_OUT-1:0]   sat_data;
   logic signed [W1-1:0] r_s;
   logic signed [W1-1:0] sat_max;
   logic signed [W1-1:0] sat_min;
   logic                 ovf_evt;
   logic                 flag_d;
   logic [NB_CNT-1:0]    cnt_d;

   assign s1_adv    = !s2_vld || i_ready;
   assign o_ready   = !s1_vld || s1_adv;
   assign o_valid   = s2_vld;
   assign o_sat_hit = st_q.sat_hit;

   rnd_core #(
      .NBW_IN       (NBW_IN),
      .NB_FRAC_DROP (NB_FRAC_DROP)
   ) u_rnd (
      .x    (i_data),
      .mode (rnd_mode_e'(i_mode)),
      .r    (rnd_r)
   );

   always_comb begin
      sat_max = '0;
      sat_max[NBW_OUT-2:0] = '1;
      sat_min = '1;
      sat_min[NBW_OUT-2:0] = '0;
      if (SYM_SAT != 0) sat_min[0] = 1'b1;
   end

   assign r_s = $signed(s1_r);

   always_comb begin
      st_d.sat_hit = (r_s > sat_max) || (r_s < sat_min);
      sat_data     = s1_r[NBW_OUT-1:0];
      if (s1_sat_en && st_d.sat_hit) begin
         sat_data = r_s[W1-1] ? sat_min[NBW_OUT-1:0] : sat_max[NBW_OUT-1:0];
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         s1_vld    <= 1'b0;
         s1_r      <= '0;
         s1_sat_en <= 1'b0;
         s2_vld    <= 1'b0;
         o_data    <= '0;
         st_q      <= '0;
      end else begin
         if (o_ready) begin
            s1_vld <= i_valid;
            if (i_valid) begin
               s1_r      <= rnd_r;
               s1_sat_en <= i_sat_en;
            end
         end
         if (s1_adv) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
               o_data <= sat_data;
               st_q   <= st_d;
            end
         end
      end
   end

   assign ovf_evt = s2_vld && i_ready && st_q.sat_hit;

   // Clear is applied first so a coincident overflow still counts as the first event.
   always_comb begin
      flag_d = o_ovf_flag;
      cnt_d  = o_ovf_cnt;
      if (i_ovf_clr) begin
         flag_d = 1'b0;
         cnt_d  = '0;
      end
      if (ovf_evt) begin
         flag_d = 1'b1;
         if (cnt_d != '1) cnt_d = cnt_d + NB_CNT'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_ovf_flag <= 1'b0;
         o_ovf_cnt  <= '0;
      end else begin
         o_ovf_flag <= flag_d;
         o_ovf_cnt  <= cnt_d;
      end
   end

endmodule
